// File: rtl/inventory_ctrl_pkg.sv
// inventory_ctrl_pkg: shared sizes and FSM encoding for the inventory controller.
package inventory_ctrl_pkg;
   localparam int NUM_ITEMS = 8;
   localparam int COUNT_W   = 4;
   localparam int IDX_W     = 4;
   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_DECR = 2'b01;
   localparam logic [1:0] S_ACK  = 2'b10;
endpackage

// File: rtl/inventory_ctrl_if.sv
// inventory_ctrl_if: payment-side handshake, stock load and status bundle.
interface inventory_ctrl_if
   import inventory_ctrl_pkg::*;
#(
   parameter int NUM_ITEMS = inventory_ctrl_pkg::NUM_ITEMS,
   parameter int COUNT_W   = inventory_ctrl_pkg::COUNT_W
);
   logic                           load;
   logic [NUM_ITEMS*COUNT_W-1:0]   storeStock;
   logic                           reduceInventory;
   logic [IDX_W-1:0]               curIndex;
   logic                           reduceInventoryDone;
   logic [NUM_ITEMS-1:0]           soldOut;
   logic [COUNT_W-1:0]             itemCount;
   logic                           dispenseErr;
   logic [7:0]                     totalSold;
   modport slave (
      input  load, storeStock, reduceInventory, curIndex,
      output reduceInventoryDone, soldOut, itemCount, dispenseErr, totalSold
   );
   modport master (
      output load, storeStock, reduceInventory, curIndex,
      input  reduceInventoryDone, soldOut, itemCount, dispenseErr, totalSold
   );
endinterface

// File: rtl/inventory_ctrl_stock_table.sv
// stock_table: per-slot stock counters with bulk load, guarded single-slot
// decrement and sold-out decode.
module stock_table
   import inventory_ctrl_pkg::*;
#(
   parameter int NUM_ITEMS = inventory_ctrl_pkg::NUM_ITEMS,
   parameter int COUNT_W   = inventory_ctrl_pkg::COUNT_W
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         load_i,
   input  logic [NUM_ITEMS*COUNT_W-1:0] stock_i,
   input  logic                         dec_i,
   input  logic [IDX_W-1:0]             dec_idx_i,
   input  logic [IDX_W-1:0]             rd_idx_i,
   output logic [COUNT_W-1:0]           count_o,
   output logic [NUM_ITEMS-1:0]         sold_out_o,
   output logic                         dec_ok_o
);
   logic [COUNT_W-1:0] cnt_q [NUM_ITEMS];
   logic [COUNT_W-1:0] cnt_d [NUM_ITEMS];
   // Out-of-range indices match no slot, so they read 0 and never decrement.
   always_comb begin
      count_o  = '0;
      dec_ok_o = 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         count_o  = (int'(rd_idx_i) == i) ? cnt_q[i] : count_o;
         dec_ok_o = dec_ok_o | ((int'(dec_idx_i) == i) && (cnt_q[i] != '0));
      end
   end
   always_comb begin
      for (int i = 0; i < NUM_ITEMS; i++)
         cnt_d[i] = load_i ? stock_i[i*COUNT_W +: COUNT_W] :
                    (dec_i && int'(dec_idx_i) == i && cnt_q[i] != '0) ? cnt_q[i] - 1'b1 :
                    cnt_q[i];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < NUM_ITEMS; i++)
         cnt_q[i] <= !rst_n ? '0 : cnt_d[i];
   end
   for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_so
      assign sold_out_o[g] = (cnt_q[g] == '0);
   end
endmodule

// File: rtl/inventory_ctrl.sv
// inventory_ctrl: four-phase dispense handshake FSM over a stock table, with
// refusal flag and saturating sales counter.
module inventory_ctrl
   import inventory_ctrl_pkg::*;
#(
   parameter int NUM_ITEMS = inventory_ctrl_pkg::NUM_ITEMS,
   parameter int COUNT_W   = inventory_ctrl_pkg::COUNT_W
) (
   input  logic             clk,
   input  logic             rst,
   inventory_ctrl_if.slave  bus
);
   logic [1:0]       rst_sync_q;
   logic             rst_n;
   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             done_q, done_d, err_q, err_d;
   logic [7:0]       sold_q, sold_d;
   logic             load_en, dec_en, dec_ok;
   // Asserts asynchronously, releases two edges later so no flop sees a runt release.
   always_ff @(posedge clk or negedge rst)
      if (!rst) rst_sync_q <= 2'b00;
      else      rst_sync_q <= {rst_sync_q[0], 1'b1};
   assign rst_n = rst_sync_q[1];
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      done_d  = done_q;
      err_d   = err_q;
      sold_d  = sold_q;
      load_en = 1'b0;
      dec_en  = 1'b0;
      case (state_q)
         S_IDLE: begin
            state_d = bus.reduceInventory ? S_DECR : S_IDLE;
            idx_d   = bus.reduceInventory ? bus.curIndex : idx_q;
            load_en = bus.load && !bus.reduceInventory;
            err_d   = load_en ? 1'b0 : err_q;
         end
         S_DECR: begin
            dec_en  = dec_ok;
            err_d   = !dec_ok;
            sold_d  = (dec_ok && sold_q != 8'hFF) ? sold_q + 8'd1 : sold_q;
            done_d  = 1'b1;
            state_d = S_ACK;
         end
         S_ACK: begin
            done_d  = bus.reduceInventory;
            state_d = bus.reduceInventory ? S_ACK : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         sold_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         err_q   <= err_d;
         sold_q  <= sold_d;
      end
   stock_table #(.NUM_ITEMS(NUM_ITEMS), .COUNT_W(COUNT_W)) u_table (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (load_en),
      .stock_i   (bus.storeStock),
      .dec_i     (dec_en),
      .dec_idx_i (idx_q),
      .rd_idx_i  (bus.curIndex),
      .count_o   (bus.itemCount),
      .sold_out_o(bus.soldOut),
      .dec_ok_o  (dec_ok)
   );
   assign bus.reduceInventoryDone = done_q;
   assign bus.dispenseErr         = err_q;
   assign bus.totalSold           = sold_q;
endmodule

// File: tb/tb_inventory_ctrl.sv
// tb_inventory_ctrl: directed handshakes with a scoreboard checked on each Done rise.
module tb_inventory_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   errs = 0;
   logic done_prev = 1'b0;
   typedef struct { logic [31:0] ic, err, sold, so; } exp_t;
   exp_t q[$];
   inventory_ctrl_if #(.NUM_ITEMS(8), .COUNT_W(4)) bus ();
   inventory_ctrl #(.NUM_ITEMS(8), .COUNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic push(input logic [31:0] ic, err, sold, so);
      exp_t e;
      e.ic = ic; e.err = err; e.sold = sold; e.so = so;
      q.push_back(e);
   endtask
   // Monitor: every Done rise must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (bus.reduceInventoryDone && !done_prev) begin
         if (q.size() == 0) chk("sb_unexpected_done", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("sb_itemCount", 32'(bus.itemCount), e.ic);
            chk("sb_dispenseErr", 32'(bus.dispenseErr), e.err);
            chk("sb_totalSold", 32'(bus.totalSold), e.sold);
            chk("sb_soldOut", 32'(bus.soldOut), e.so);
         end
      end
      done_prev = bus.reduceInventoryDone;
   end
   task automatic start(input logic [3:0] idx);
      @(posedge clk); #1;
      bus.curIndex = idx;
      bus.reduceInventory = 1'b1;
   endtask
   task automatic wait_done(input int exp_lat);
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!bus.reduceInventoryDone && n < 20);
      if (!bus.reduceInventoryDone) chk("done_timeout", 32'(bus.reduceInventoryDone), 32'd1);
      else if (exp_lat > 0) chk("done_latency", n, exp_lat);
   endtask
   task automatic finish_hs();
      @(posedge clk); #1;
      bus.reduceInventory = 1'b0;
      @(posedge clk); #1;
      chk("done_fall", 32'(bus.reduceInventoryDone), 32'd0);
   endtask
   task automatic hs(input logic [3:0] idx, input int hold, input bit pulse_load);
      start(idx);
      wait_done(2);
      for (int i = 0; i < hold; i++) begin
         if (pulse_load && i == 2) begin
            bus.load = 1'b1;
            bus.storeStock = '1;
         end
         @(posedge clk); #1;
         bus.load = 1'b0;
         chk("done_hold", 32'(bus.reduceInventoryDone), 32'd1);
      end
      finish_hs();
   endtask
   task automatic do_load(input logic [31:0] stock);
      @(posedge clk); #1;
      bus.storeStock = stock;
      bus.load = 1'b1;
      @(posedge clk); #1;
      bus.load = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end
   initial begin
      rst = 1'b1;
      bus.load = 1'b0;
      bus.storeStock = '0;
      bus.reduceInventory = 1'b0;
      bus.curIndex = 4'd3;
      #1 rst = 1'b0;
      #3;
      chk("rst_done", 32'(bus.reduceInventoryDone), 32'd0);
      chk("rst_soldOut", 32'(bus.soldOut), 32'hFF);
      chk("rst_itemCount", 32'(bus.itemCount), 32'd0);
      chk("rst_err", 32'(bus.dispenseErr), 32'd0);
      chk("rst_totalSold", 32'(bus.totalSold), 32'd0);
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      do_load(32'h0000_2000);
      @(negedge clk);
      chk("load_soldOut", 32'(bus.soldOut), 32'hF7);
      chk("load_itemCount", 32'(bus.itemCount), 32'd2);
      push(32'd1, 32'd0, 32'd1, 32'hF7);
      hs(4'd3, 0, 1'b0);
      push(32'd0, 32'd0, 32'd2, 32'hFF);
      hs(4'd3, 0, 1'b0);
      push(32'd0, 32'd1, 32'd2, 32'hFF);
      hs(4'd3, 0, 1'b0);
      chk("err_held", 32'(bus.dispenseErr), 32'd1);
      do_load(32'h0050_1000);
      chk("load_clears_err", 32'(bus.dispenseErr), 32'd0);
      chk("reload_soldOut", 32'(bus.soldOut), 32'hD7);
      push(32'd0, 32'd1, 32'd2, 32'hD7);
      hs(4'd9, 0, 1'b0);
      chk("bad_idx_itemCount", 32'(bus.itemCount), 32'd0);
      bus.curIndex = 4'd3; #1;
      chk("bad_idx_slot3", 32'(bus.itemCount), 32'd1);
      bus.curIndex = 4'd5; #1;
      chk("bad_idx_slot5", 32'(bus.itemCount), 32'd5);
      push(32'd4, 32'd0, 32'd3, 32'hD7);
      hs(4'd5, 8, 1'b1);
      chk("hold_slot5", 32'(bus.itemCount), 32'd4);
      bus.curIndex = 4'd3; #1;
      chk("ack_load_ignored", 32'(bus.itemCount), 32'd1);
      chk("hold_totalSold", 32'(bus.totalSold), 32'd3);
      push(32'd0, 32'd0, 32'd4, 32'hDF);
      start(4'd3);
      wait_done(2);
      @(posedge clk); #1 rst = 1'b0;
      #1;
      chk("midrst_done", 32'(bus.reduceInventoryDone), 32'd0);
      chk("midrst_soldOut", 32'(bus.soldOut), 32'hFF);
      chk("midrst_itemCount", 32'(bus.itemCount), 32'd0);
      chk("midrst_totalSold", 32'(bus.totalSold), 32'd0);
      chk("midrst_err", 32'(bus.dispenseErr), 32'd0);
      @(posedge clk); #1 rst = 1'b1;
      push(32'd0, 32'd1, 32'd0, 32'hFF);
      wait_done(0);
      finish_hs();
      @(negedge clk);
      chk("sb_empty", q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
